// File: rtl/serial_adder.sv
// Bit-serial adder: {c_out, sum} = a + b + c_in, one bit per clock, LSB first, one full_adder cell.
// Latency: WIDTH cycles from the accepting edge to done; one result per WIDTH+1 cycles.
// Backpressure: none; start is ignored while busy, results hold until the next completion.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_c;
    logic             load;
    logic             last;

    full_adder u_fa (
        .x     (a_sh[0]),
        .y     (b_sh[0]),
        .c_in  (carry),
        .s     (fa_s),
        .c_out (fa_c)
    );

    assign load = start && (state_q != SHIFT);
    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
        end else if (state_q == SHIFT) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum   <= res_nxt;
                c_out <= fa_c;
            end
        end
    end

    // Only WIDTH-1 result bits need storage: the last bit goes straight from the cell into sum.
    if (WIDTH > 1) begin : g_res
        logic [WIDTH-2:0] res_sh;
        assign res_nxt = {fa_s, res_sh};
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                 res_sh <= '0;
            else if (state_q == SHIFT)  res_sh <= res_nxt[WIDTH-1:1];
        end
    end else begin : g_res1
        assign res_nxt = fa_s;
    end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder at WIDTH 8, 1 and 13: directed scenarios plus random regression.
module tb_serial_adder;
    typedef struct {
        logic [13:0] val;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst8, rsto;

    logic       start8, c8, busy8, done8, co8;
    logic [7:0] a8, b8, sum8;
    logic       start1, c1, busy1, done1, co1;
    logic [0:0] a1, b1, sum1;
    logic        start13, c13, busy13, done13, co13;
    logic [12:0] a13, b13, sum13;

    int   cyc, n_vec, n_err;
    exp_t q8[$];
    exp_t q1[$];
    exp_t q13[$];
    logic [7:0] ha[3];
    logic [7:0] hb[3];
    logic       hc[3];
    int         td[3];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8), .start(start8), .a(a8), .b(b8), .c_in(c8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(co8)
    );
    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rsto), .start(start1), .a(a1), .b(b1), .c_in(c1),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(co1)
    );
    serial_adder #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rsto), .start(start13), .a(a13), .b(b13), .c_in(c13),
        .busy(busy13), .done(done13), .sum(sum13), .c_out(co13)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        int g, nd;
        exp_t e;
        cyc = 0; n_vec = 0; n_err = 0;
        rst8 = 1'b0; rsto = 1'b0;
        start8 = 0; a8 = '0; b8 = '0; c8 = 0;
        start1 = 0; a1 = '0; b1 = '0; c1 = 0;
        start13 = 0; a13 = '0; b13 = '0; c13 = 0;
        ha[0] = 8'h01; hb[0] = 8'h01; hc[0] = 1'b0;
        ha[1] = 8'h80; hb[1] = 8'h80; hc[1] = 1'b0;
        ha[2] = 8'h7F; hb[2] = 8'h00; hc[2] = 1'b1;

        // Monitor: acceptance observed on the rising edge, results checked on the falling edge.
        fork
            forever begin
                @(posedge clk);
                cyc++;
                if (rst8 && start8 && !busy8) q8.push_back('{14'(a8) + 14'(b8) + 14'(c8), cyc});
                if (rsto && start1 && !busy1) q1.push_back('{14'(a1) + 14'(b1) + 14'(c1), cyc});
                if (rsto && start13 && !busy13) q13.push_back('{14'(a13) + 14'(b13) + 14'(c13), cyc});
                @(negedge clk);
                if (done8) begin
                    if (q8.size() == 0) check("w8_spurious_done", 32'(done8), 32'(0));
                    else begin
                        e = q8.pop_front();
                        check("w8_result", 32'({co8, sum8}), 32'(e.val));
                        check("w8_latency", 32'(cyc - e.acc), 32'(8));
                    end
                end
                if (done1) begin
                    if (q1.size() == 0) check("w1_spurious_done", 32'(done1), 32'(0));
                    else begin
                        e = q1.pop_front();
                        check("w1_result", 32'({co1, sum1}), 32'(e.val));
                        check("w1_latency", 32'(cyc - e.acc), 32'(1));
                    end
                end
                if (done13) begin
                    if (q13.size() == 0) check("w13_spurious_done", 32'(done13), 32'(0));
                    else begin
                        e = q13.pop_front();
                        check("w13_result", 32'({co13, sum13}), 32'(e.val));
                        check("w13_latency", 32'(cyc - e.acc), 32'(13));
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'(0));
        check("rst_done", 32'(done8), 32'(0));
        check("rst_sum", 32'(sum8), 32'(0));
        check("rst_cout", 32'(co8), 32'(0));
        check("rst_sum13", 32'({co13, sum13}), 32'(0));
        rst8 = 1'b1; rsto = 1'b1;
        @(negedge clk);

        fork
            begin : rnd_w1
                for (int i = 0; i < 200; i++) begin
                    g = 0;
                    while (busy1 && g < 40) begin @(negedge clk); g++; end
                    if (g >= 40) check("w1_stuck_busy", 32'(busy1), 32'(0));
                    a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
                    start1 = 1'b1;
                    @(negedge clk);
                    start1 = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin : rnd_w13
                int g13;
                for (int i = 0; i < 200; i++) begin
                    g13 = 0;
                    while (busy13 && g13 < 40) begin @(negedge clk); g13++; end
                    if (g13 >= 40) check("w13_stuck_busy", 32'(busy13), 32'(0));
                    a13 = 13'($urandom); b13 = 13'($urandom); c13 = 1'($urandom);
                    start13 = 1'b1;
                    @(negedge clk);
                    start13 = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin : main_w8
                int g8, nb;
                // FF + 01: busy for exactly 8 cycles, wraps to 00 with carry.
                a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; start8 = 1'b1;
                @(negedge clk);
                start8 = 1'b0;
                nb = 0; g8 = 0;
                while (!done8 && g8 < 40) begin
                    if (busy8) nb++;
                    @(negedge clk); g8++;
                end
                check("t1_busy_cycles", 32'(nb), 32'(8));
                check("t1_done_seen", 32'(done8), 32'(1));

                // Back-to-back from DONE; outputs hold the previous result meanwhile.
                a8 = 8'h5A; b8 = 8'hA5; c8 = 1'b1; start8 = 1'b1;
                @(negedge clk);
                start8 = 1'b0;
                check("t2_no_idle_gap", 32'({busy8, done8}), 32'(2));
                g8 = 0;
                while (!done8 && g8 < 40) begin
                    check("t2_hold", 32'({co8, sum8}), 32'(9'h100));
                    @(negedge clk); g8++;
                end
                check("t2_done_seen", 32'(done8), 32'(1));
                @(negedge clk);

                // A second start mid-operation must be ignored.
                a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; start8 = 1'b1;
                @(negedge clk);
                start8 = 1'b0;
                @(negedge clk);
                a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; start8 = 1'b1;
                @(negedge clk);
                start8 = 1'b0;
                nd = 0;
                repeat (12) begin
                    if (done8) nd++;
                    @(negedge clk);
                end
                check("t3_done_count", 32'(nd), 32'(1));
                check("t3_result", 32'({co8, sum8}), 32'(9'h030));

                // Reset mid-SHIFT discards the operation.
                a8 = 8'hF0; b8 = 8'h0F; c8 = 1'b0; start8 = 1'b1;
                @(negedge clk);
                start8 = 1'b0;
                repeat (3) @(negedge clk);
                rst8 = 1'b0;
                #1;
                check("t4_rst_busy", 32'(busy8), 32'(0));
                check("t4_rst_done", 32'(done8), 32'(0));
                check("t4_rst_sum", 32'(sum8), 32'(0));
                check("t4_rst_cout", 32'(co8), 32'(0));
                q8.delete();
                @(negedge clk);
                rst8 = 1'b1;
                nd = 0;
                repeat (10) begin
                    if (done8) nd++;
                    @(negedge clk);
                end
                check("t4_no_done", 32'(nd), 32'(0));
                a8 = 8'h12; b8 = 8'h34; c8 = 1'b1; start8 = 1'b1;
                @(negedge clk);
                start8 = 1'b0;
                g8 = 0;
                while (!done8 && g8 < 40) begin @(negedge clk); g8++; end
                check("t4_done_seen", 32'(done8), 32'(1));
                @(negedge clk);

                // start held high: a result every WIDTH+1 cycles.
                a8 = ha[0]; b8 = hb[0]; c8 = hc[0]; start8 = 1'b1;
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    g8 = 0;
                    while (!done8 && g8 < 40) begin @(negedge clk); g8++; end
                    td[k] = cyc;
                    if (k < 2) begin a8 = ha[k+1]; b8 = hb[k+1]; c8 = hc[k+1]; end
                    @(negedge clk);
                    if (k == 1) start8 = 1'b0;
                end
                check("t5_period_1", 32'(td[1] - td[0]), 32'(9));
                check("t5_period_2", 32'(td[2] - td[1]), 32'(9));
                check("t5_final", 32'({co8, sum8}), 32'(9'h080));

                for (int i = 0; i < 1000; i++) begin
                    g8 = 0;
                    while (busy8 && g8 < 40) begin @(negedge clk); g8++; end
                    if (g8 >= 40) check("w8_stuck_busy", 32'(busy8), 32'(0));
                    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
                    start8 = 1'b1;
                    @(negedge clk);
                    start8 = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join

        repeat (30) @(negedge clk);
        check("w8_pending", 32'(q8.size()), 32'(0));
        check("w1_pending", 32'(q1.size()), 32'(0));
        check("w13_pending", 32'(q13.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
